// File: rtl/fade_pkg.sv
// rtl/fade_pkg.sv - shared state codes and defaults for the fade envelope and PWM stage
package fade_pkg;

  localparam int          WIDTH_DEF     = 16;
  localparam logic [15:0] MAX_LEVEL_DEF = 16'hFF00;

  typedef enum logic [1:0] {
    HOLD_LOW  = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD_HIGH = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_t;

endpackage

// File: rtl/fade_gamma_sq.sv
// rtl/fade_gamma_sq.sv - registered square-law shaper with bypass, one cycle latency
module fade_gamma_sq
  import fade_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter bit GAMMA = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] target_q
);

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   shaped;

  assign product = {{WIDTH{1'b0}}, level} * {{WIDTH{1'b0}}, level};

  // Upper half of the square keeps full scale mapped to near full scale.
  assign shaped = GAMMA ? WIDTH'(product >> WIDTH) : level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
    end else begin
      target_q <= shaped;
    end
  end

endmodule

// File: rtl/fade_envelope_gen.sv
// rtl/fade_envelope_gen.sv - breathing envelope generator feeding a glitch-free PWM compare
module fade_envelope_gen
  import fade_pkg::*;
#(
  parameter int               WIDTH         = WIDTH_DEF,
  parameter int               STEP_DIV_BITS = 17,
  parameter logic [WIDTH-1:0] MAX_LEVEL     = MAX_LEVEL_DEF,
  parameter int               HOLD_TICKS    = 8,
  parameter bit               GAMMA         = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic [WIDTH-1:0] step,
  input  logic             period_wrap,
  output logic [WIDTH-1:0] compare,
  output logic             compare_upd,
  output logic [1:0]       state,
  output logic             peak
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  fade_state_t              state_q;
  fade_state_t              state_d;
  logic [STEP_DIV_BITS-1:0] prescaler;
  logic                     step_tick;
  logic [WIDTH-1:0]         level;
  logic [WIDTH-1:0]         level_d;
  logic [WIDTH-1:0]         target_q;
  logic [7:0]               hold_cnt;
  logic [7:0]               hold_d;
  logic [WIDTH:0]           sum;
  logic                     at_top;
  logic                     at_bottom;
  logic                     hold_done;
  logic                     peak_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescaler <= '0;
    end else if (en) begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign step_tick = en & (&prescaler);

  // One extra bit so a large step cannot wrap past the ceiling unnoticed.
  assign sum       = {1'b0, level} + {1'b0, step};
  assign at_top    = sum >= {1'b0, MAX_LEVEL};
  assign at_bottom = level <= step;
  assign hold_done = hold_cnt == HOLD_LAST;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RAMP_UP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (step_tick) begin
      case (state_q)
        RAMP_UP:   if (at_top)    state_d = HOLD_HIGH;
        HOLD_HIGH: if (hold_done) state_d = RAMP_DOWN;
        RAMP_DOWN: if (at_bottom) state_d = HOLD_LOW;
        HOLD_LOW:  if (hold_done) state_d = RAMP_UP;
        default:                  state_d = RAMP_UP;
      endcase
    end
  end

  always_comb begin
    level_d = level;
    hold_d  = hold_cnt;
    peak_d  = 1'b0;
    if (step_tick) begin
      case (state_q)
        RAMP_UP: begin
          if (at_top) begin
            level_d = MAX_LEVEL;
            hold_d  = '0;
            peak_d  = 1'b1;
          end else begin
            level_d = sum[WIDTH-1:0];
          end
        end
        HOLD_HIGH, HOLD_LOW: begin
          hold_d = hold_done ? 8'd0 : hold_cnt + 8'd1;
        end
        RAMP_DOWN: begin
          if (at_bottom) begin
            level_d = '0;
            hold_d  = '0;
          end else begin
            level_d = level - step;
          end
        end
        default: begin
          level_d = level;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level    <= '0;
      hold_cnt <= '0;
      peak     <= 1'b0;
    end else begin
      level    <= level_d;
      hold_cnt <= hold_d;
      peak     <= peak_d;
    end
  end

  fade_gamma_sq #(
    .WIDTH (WIDTH),
    .GAMMA (GAMMA)
  ) u_gamma (
    .clk      (CLK),
    .rst_n    (RST_N),
    .level    (level),
    .target_q (target_q)
  );

  // Compare only moves on the PWM wrap so a period is never cut short.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      compare     <= '0;
      compare_upd <= 1'b0;
    end else begin
      compare_upd <= period_wrap;
      if (period_wrap) begin
        compare <= target_q;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fade_envelope_gen.sv
// tb/tb_fade_envelope_gen.sv - scoreboard bench for fade_envelope_gen, linear and gamma builds
module tb_fade_envelope_gen;

  localparam int          SDB  = 2;
  localparam int          HT   = 2;
  localparam int unsigned PMAX = (1 << SDB) - 1;
  localparam int unsigned MAXL = 32'hFF00;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en = 1'b0;
  logic        period_wrap = 1'b0;
  logic [15:0] step = 16'h0;

  logic [15:0] cmp0, cmp1;
  logic        upd0, upd1, pk0, pk1;
  logic [1:0]  st0, st1;

  int checks = 0;
  int errors = 0;

  int unsigned m_presc = 0, m_level = 0, m_phase = 1, m_hold = 0;
  int unsigned m_target = 0, m_target_g = 0;
  bit          m_upd = 0, m_peak = 0;
  int unsigned q0[$], q1[$];
  logic [15:0] prev0 = 16'h0, prev1 = 16'h0;

  bit          collect = 0;
  int unsigned seq[$];
  int          peak_cnt = 0, hi_cycles = 0, lo_cycles = 0;

  always #5 CLK = ~CLK;

  fade_envelope_gen #(.WIDTH(16), .STEP_DIV_BITS(SDB), .MAX_LEVEL(16'hFF00),
                      .HOLD_TICKS(HT), .GAMMA(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .en(en), .step(step), .period_wrap(period_wrap),
    .compare(cmp0), .compare_upd(upd0), .state(st0), .peak(pk0));

  fade_envelope_gen #(.WIDTH(16), .STEP_DIV_BITS(SDB), .MAX_LEVEL(16'hFF00),
                      .HOLD_TICKS(HT), .GAMMA(1'b1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .en(en), .step(step), .period_wrap(period_wrap),
    .compare(cmp1), .compare_upd(upd1), .state(st1), .peak(pk1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    m_presc = 0; m_level = 0; m_phase = 1; m_hold = 0;
    m_target = 0; m_target_g = 0; m_upd = 0; m_peak = 0;
    q0.delete(); q1.delete();
    prev0 = 16'h0; prev1 = 16'h0;
  endtask

  // Envelope rules in plain arithmetic; the compare pipeline is level -> target -> compare.
  task model_step();
    bit tick;
    tick = en && (m_presc == PMAX);
    m_upd = period_wrap;
    if (period_wrap) begin
      q0.push_back(m_target);
      q1.push_back(m_target_g);
    end
    m_target   = m_level;
    m_target_g = (m_level * m_level) >> 16;
    m_peak = 0;
    if (tick) begin
      case (m_phase)
        1: if (m_level + step >= MAXL) begin
             m_level = MAXL; m_phase = 2; m_hold = 0; m_peak = 1;
           end else m_level = m_level + step;
        2: if (m_hold == HT - 1) begin m_phase = 3; m_hold = 0; end
           else m_hold = m_hold + 1;
        3: if (m_level <= step) begin m_level = 0; m_phase = 0; m_hold = 0; end
           else m_level = m_level - step;
        default: if (m_hold == HT - 1) begin m_phase = 1; m_hold = 0; end
                 else m_hold = m_hold + 1;
      endcase
    end
    if (en) m_presc = (m_presc + 1) % (PMAX + 1);
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) model_reset();
    else model_step();
  end

  // Monitor: pops the scoreboard whenever the DUT announces a load.
  initial forever begin
    @(negedge CLK);
    check("state0", st0, m_phase);
    check("state1", st1, m_phase);
    check("peak0", pk0, m_peak);
    check("peak1", pk1, m_peak);
    check("upd0", upd0, m_upd);
    check("upd1", upd1, m_upd);
    if (upd0) begin
      check("sb0_depth", q0.size(), 1);
      if (q0.size() > 0) check("sb0_compare", cmp0, q0.pop_front());
      if (cmp0 == 16'h8000) check("gamma_half", cmp1, 16'h4000);
      if (cmp0 == 16'hFF00) check("gamma_top", cmp1, 16'hFE01);
      if (cmp0 == 16'h0000) check("gamma_zero", cmp1, 16'h0000);
      if (collect && cmp0 != prev0) seq.push_back(cmp0);
    end else begin
      check("hold0", cmp0, prev0);
    end
    if (upd1) begin
      check("sb1_depth", q1.size(), 1);
      if (q1.size() > 0) check("sb1_compare", cmp1, q1.pop_front());
    end else begin
      check("hold1", cmp1, prev1);
    end
    if (collect) begin
      if (pk0) peak_cnt++;
      if (st0 == 2'd2) hi_cycles++;
      if (st0 == 2'd0) lo_cycles++;
    end
    prev0 = cmp0;
    prev1 = cmp1;
  end

  task automatic do_reset();
    @(negedge CLK); #2 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
  endtask

  initial begin
    int n;
    int unsigned exp_seq[9] = '{32'h4000, 32'h8000, 32'hC000, 32'hFF00,
                                32'hBF00, 32'h7F00, 32'h3F00, 32'h0000, 32'h4000};
    logic [1:0]  s_st;
    logic [15:0] s_cmp;
    int          upd_cnt;

    // Reset values and first-tick latency
    en = 1'b1; step = 16'h1000; period_wrap = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_compare", cmp0, 16'h0);
    check("rst_upd", upd0, 1'b0);
    check("rst_peak", pk0, 1'b0);
    check("rst_state", st0, 2'd1);
    #2 RST_N = 1'b1;
    n = 0;
    while (cmp0 !== 16'h1000 && n < 50) begin @(negedge CLK); n++; end
    check("first_load_latency", n, 6);
    repeat (4) @(negedge CLK);
    check("ramp_second", cmp0, 16'h2000);
    repeat (4) @(negedge CLK);
    check("ramp_third", cmp0, 16'h3000);

    // Full breathing cycle
    do_reset();
    step = 16'h4000;
    seq.delete(); peak_cnt = 0; hi_cycles = 0; lo_cycles = 0;
    collect = 1;
    n = 0;
    while (seq.size() < 9 && n < 300) begin @(negedge CLK); n++; end
    collect = 0;
    check("cycle_len", seq.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < seq.size()) check($sformatf("cycle_seq%0d", i), seq[i], exp_seq[i]);
    check("peak_count", peak_cnt, 1);
    check("hold_high_cycles", hi_cycles, 4 * HT);
    check("hold_low_cycles", lo_cycles, 4 * HT);

    // Glitch-free loads: wrap every 16 cycles, level steps every 4
    step = 16'h1000;
    upd_cnt = 0;
    for (int i = 0; i <= 160; i++) begin
      @(negedge CLK);
      if (i >= 1 && upd0) upd_cnt++;
      period_wrap = (i < 160) && (i % 16 == 15);
    end
    check("wrap_loads", upd_cnt, 10);

    // Freeze mid ramp-up
    do_reset();
    step = 16'h0100; period_wrap = 1'b1;
    repeat (10) @(negedge CLK);
    en = 1'b0;
    repeat (3) @(negedge CLK);
    s_st = st0; s_cmp = cmp0;
    repeat (17) @(negedge CLK);
    check("freeze_state", st0, s_st);
    check("freeze_compare", cmp0, s_cmp);
    en = 1'b1;
    repeat (40) @(negedge CLK);

    // Randomized run
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      en = ($urandom_range(0, 9) != 0);
      period_wrap = ($urandom_range(0, 5) == 0);
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0:       step = 16'h0;
          1:       step = 16'($urandom_range(1, 255));
          2:       step = 16'($urandom_range(256, 16'h3FFF));
          default: step = 16'($urandom_range(16'h4000, 16'hFFFF));
        endcase
      end
    end

    // Async reset in ramp-down at 0x7F00, then restart
    do_reset();
    en = 1'b1; step = 16'h4000; period_wrap = 1'b1;
    n = 0;
    while (!(m_phase == 3 && m_level == 32'h7F00) && n < 300) begin @(negedge CLK); n++; end
    check("reach_rampdown", n < 300, 1'b1);
    @(posedge CLK); #3 RST_N = 1'b0;
    #1;
    check("async_compare0", cmp0, 16'h0);
    check("async_compare1", cmp1, 16'h0);
    check("async_state", st0, 2'd1);
    check("async_upd", upd0, 1'b0);
    check("async_peak", pk0, 1'b0);
    @(negedge CLK); #2 RST_N = 1'b1;
    seq.delete(); collect = 1;
    n = 0;
    while (seq.size() < 2 && n < 100) begin @(negedge CLK); n++; end
    collect = 0;
    check("restart_len", seq.size(), 2);
    if (seq.size() >= 2) begin
      check("restart_first", seq[0], 32'h4000);
      check("restart_second", seq[1], 32'h8000);
    end

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/fade_envelope_gen.md
Name: fade_envelope_gen

Overview:
- Generates the duty-cycle compare value for the downstream PWM stage, which compares it against a free-running 16-bit counter and sets output high while counter < compare.
- Produces a breathing envelope: ramp up, hold at top, ramp down, hold at bottom, repeat. Optional square-law gamma correction.
- Loads a new compare value only on the PWM period wrap, so the PWM output never glitches mid-period.

Parameters:
- WIDTH, 16, width of level and compare; matches the downstream PWM counter.
- STEP_DIV_BITS, 17, prescaler width; one step tick every 2^STEP_DIV_BITS enabled cycles.
- MAX_LEVEL, 16'hFF00, saturation ceiling of the ramp.
- HOLD_TICKS, 8, step ticks spent in each hold state; legal range 1..255.
- GAMMA, 1, 1 = compare is (level*level)>>WIDTH; 0 = compare is level.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- en  in  1  1 = prescaler and FSM advance; 0 = frozen
- step  in  WIDTH  level increment/decrement per step tick
- period_wrap  in  1  one-cycle pulse from the PWM stage when its counter wraps to 0
- compare  out  WIDTH  duty compare value to the PWM stage
- compare_upd  out  1  one-cycle pulse, high in the cycle compare takes a new load
- state  out  2  FSM state code
- peak  out  1  one-cycle pulse on entry to HOLD_HIGH

Behaviour:
- Reset is asynchronous and takes effect without a clock edge. Reset values:
  - prescaler = 0, level = 0, hold_cnt = 0, target_q = 0
  - compare = 0, compare_upd = 0, peak = 0
  - state = RAMP_UP
- Prescaler:
  - Increments only when en = 1 and wraps modulo 2^STEP_DIV_BITS.
  - step_tick = en AND (prescaler == all-ones), so the tick fires in the cycle the prescaler wraps.
- FSM state codes: HOLD_LOW = 0, RAMP_UP = 1, HOLD_HIGH = 2, RAMP_DOWN = 3. The FSM acts only on step_tick.
  - RAMP_UP: sum = level + step, computed at WIDTH+1 bits.
    - If sum >= MAX_LEVEL: level = MAX_LEVEL, go to HOLD_HIGH, hold_cnt = 0, pulse peak next cycle.
    - Otherwise level = sum.
  - HOLD_HIGH: hold_cnt increments. When hold_cnt == HOLD_TICKS-1: go to RAMP_DOWN, hold_cnt = 0.
  - RAMP_DOWN:
    - If level <= step: level = 0, go to HOLD_LOW, hold_cnt = 0.
    - Otherwise level = level - step.
  - HOLD_LOW: same counting as HOLD_HIGH, then go to RAMP_UP.
- step = 0: level stays constant and a ramp state never exits. This is legal and not an error.
- step changing mid-ramp: the new value applies from the next step_tick.
- Gamma pipeline: target_q is registered from level one cycle after level changes.
  - GAMMA = 1: target_q = upper WIDTH bits of the 2*WIDTH-bit product level*level.
  - GAMMA = 0: target_q = level.
- Compare load:
  - On a cycle with period_wrap = 1: compare <= target_q and compare_upd <= 1 (both registered, visible the next cycle). Otherwise compare_upd <= 0.
  - compare is never written at any other time.
  - period_wrap and a level change in the same cycle: compare takes the old target_q.
- Latency:
  - step_tick to level: 1 cycle.
  - level to target_q: 1 cycle.
  - target_q to compare: load at the next period_wrap.
- en = 0: prescaler, level, state and hold_cnt are frozen. Compare loads still occur on period_wrap.
- Reset asserted mid-operation: all registers clear immediately. After RST_N rises, the sequence restarts from RAMP_UP with level 0.

Decomposition:
- Package fade_pkg holds:
  - FSM state codes HOLD_LOW, RAMP_UP, HOLD_HIGH, RAMP_DOWN (2-bit)
  - default WIDTH = 16 and MAX_LEVEL = 16'hFF00, shared with the PWM stage
- Sub-module fade_gamma_sq: registered squarer, WIDTH in, WIDTH out, 1-cycle latency, with a GAMMA bypass. It is instantiated once and produces target_q.

Test Plan:
- Reset: hold RST_N = 0 -> compare = 0, compare_upd = 0, peak = 0, state = 1. Release with STEP_DIV_BITS = 2, GAMMA = 0, step = 16'h1000, period_wrap tied to 1 -> compare = 0x1000 three cycles after the first step_tick, then +0x1000 every 4 cycles.
- Full cycle: GAMMA = 0, step = 16'h4000, HOLD_TICKS = 2 -> compare sequence 0x4000, 0x8000, 0xC000, 0xFF00 (clamped; peak pulses once, state = 2 for 2 ticks), then 0xBF00, 0x7F00, 0x3F00, 0x0000 (state = 0 for 2 ticks), then state = 1 and 0x4000 again.
- Gamma: GAMMA = 1 -> level 0x8000 gives compare 0x4000; level 0xFF00 gives compare 0xFE01; level 0 gives compare 0.
- Glitch-free load: period_wrap pulses every 16 cycles while level steps every 4 -> compare changes only in the cycle after each period_wrap, and compare_upd is high exactly in those cycles.
- Freeze: deassert en for 20 cycles mid-RAMP_UP -> level, state and prescaler unchanged, compare unchanged at later wraps. Re-assert -> next step_tick arrives after the remaining prescaler count.
- Async reset: assert RST_N between clock edges during RAMP_DOWN at level 0x7F00 -> compare, level and state clear before the next CLK edge. Release -> sequence restarts from 0.
